// File: rtl/fft_bf_sched.sv
// Butterfly sequencer for an in-place, memory-based radix-2 DIT FFT that
// shares one butterfly unit across all stages.
//
// Each RUN cycle issues one twiddle index (tw_k). The matching operand
// addresses are delayed TW_LAT cycles so that they leave on bf_* in the same
// cycle as the twiddle word. After every stage the sequencer idles for
// DRAIN_CYC cycles so the pipeline finishes writing before the next stage
// reads.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin an FFT (sampled only while idle)
//   tw_k         twiddle index, tw_k_valid marks live indices
//   bf_valid     addr_a/addr_b/bf_stage/bf_last valid, aligned with twiddle
//   addr_a/b     upper/lower operand addresses
//   bf_stage     stage of the butterfly on bf_*
//   bf_last      final butterfly of the FFT
//   busy         FFT in progress
//   done         one-cycle completion pulse
//   cycle_cnt    busy-cycle counter (only with FFT_PERF_EN defined)
//
// Optional feature macro: FFT_PERF_EN
module fft_bf_sched #(
  parameter int unsigned N         = 8192,
  parameter int unsigned TW_LAT    = 2,
  parameter int unsigned DRAIN_CYC = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [$clog2(N)-2:0]        tw_k,
  output logic                        tw_k_valid,
  output logic                        bf_valid,
  output logic [$clog2(N)-1:0]        addr_a,
  output logic [$clog2(N)-1:0]        addr_b,
  output logic [$clog2($clog2(N)):0]  bf_stage,
  output logic                        bf_last,
  output logic                        busy,
  output logic                        done
`ifdef FFT_PERF_EN
  ,
  output logic [31:0]                 cycle_cnt
`endif
);

  localparam int unsigned L  = $clog2(N);
  localparam int unsigned KW = L - 1;
  localparam int unsigned SW = $clog2(L) + 1;
  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [KW-1:0] J_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(L - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Upper operand address: group base (g<<(s+1)) plus position p in group.
  function automatic logic [L-1:0] calc_addr_a(input logic [SW-1:0] s,
                                                input logic [KW-1:0] j);
    logic [L-1:0] jl;
    logic [L-1:0] half;
    logic [L-1:0] p;
    logic [L-1:0] g;
    jl   = L'(j);
    half = L'(1) << s;
    p    = jl & (half - L'(1));
    g    = jl >> s;
    return (g << (32'(s) + 32'd1)) | p;
  endfunction

  // Twiddle index: position in group scaled to the N-point twiddle table.
  function automatic logic [KW-1:0] calc_tw_k(input logic [SW-1:0] s,
                                               input logic [KW-1:0] j);
    logic [L-1:0] p;
    p = L'(j) & ((L'(1) << s) - L'(1));
    return KW'(p << (KW - 32'(s)));
  endfunction

  state_t        state, state_n;
  logic [SW-1:0] s_q, s_n;
  logic [KW-1:0] j_q, j_n;
  logic [DW-1:0] d_q, d_n;

  logic [KW-1:0] tw_k_n;
  logic          tw_k_valid_n;
  logic          busy_n;
  logic          done_n;

  logic          in_v;
  logic [L-1:0]  in_a;
  logic [L-1:0]  in_b;
  logic [SW-1:0] in_st;
  logic          in_last;

  logic          pv  [TW_LAT];
  logic [L-1:0]  pa  [TW_LAT];
  logic [L-1:0]  pb  [TW_LAT];
  logic [SW-1:0] pst [TW_LAT];
  logic          pl  [TW_LAT];

  // State and loop-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      s_q   <= '0;
      j_q   <= '0;
      d_q   <= '0;
    end else begin
      state <= state_n;
      s_q   <= s_n;
      j_q   <= j_n;
      d_q   <= d_n;
    end
  end

  // Next state and next loop counters.
  always_comb begin
    state_n = state;
    s_n     = s_q;
    j_n     = j_q;
    d_n     = d_q;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          s_n     = '0;
          j_n     = '0;
        end
      end
      ST_RUN: begin
        if (j_q == J_LAST) begin
          state_n = ST_DRAIN;
          d_n     = '0;
        end else begin
          j_n = j_q + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (d_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            s_n     = s_q + SW'(1);
            j_n     = '0;
          end
        end else begin
          d_n = d_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output decode. Twiddle outputs are computed from the next butterfly so
  // tw_k is live in the RUN cycle itself; addresses are taken from the
  // current butterfly and enter the delay line one cycle later.
  always_comb begin
    tw_k_valid_n = (state_n == ST_RUN);
    tw_k_n       = tw_k;
    if (tw_k_valid_n) begin
      tw_k_n = calc_tw_k(s_n, j_n);
    end
    busy_n  = (state_n == ST_RUN) || (state_n == ST_DRAIN);
    done_n  = (state_n == ST_DONE);

    in_v    = (state == ST_RUN);
    in_a    = calc_addr_a(s_q, j_q);
    in_b    = in_a + (L'(1) << s_q);
    in_st   = s_q;
    in_last = (s_q == S_LAST) && (j_q == J_LAST);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_k       <= '0;
      tw_k_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tw_k       <= tw_k_n;
      tw_k_valid <= tw_k_valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Address delay line; payload only advances with a valid entry so the
  // outputs hold their last butterfly while bf_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TW_LAT; i++) begin
        pv[i]  <= 1'b0;
        pa[i]  <= '0;
        pb[i]  <= '0;
        pst[i] <= '0;
        pl[i]  <= 1'b0;
      end
    end else begin
      pv[0] <= in_v;
      if (in_v) begin
        pa[0]  <= in_a;
        pb[0]  <= in_b;
        pst[0] <= in_st;
        pl[0]  <= in_last;
      end
      for (int i = 1; i < TW_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pa[i]  <= pa[i-1];
          pb[i]  <= pb[i-1];
          pst[i] <= pst[i-1];
          pl[i]  <= pl[i-1];
        end
      end
    end
  end

  assign bf_valid = pv[TW_LAT-1];
  assign addr_a   = pa[TW_LAT-1];
  assign addr_b   = pb[TW_LAT-1];
  assign bf_stage = pst[TW_LAT-1];
  assign bf_last  = pl[TW_LAT-1];

`ifdef FFT_PERF_EN
  // Busy-cycle counter, cleared when an FFT is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_fft_bf_sched.sv
// Self-checking bench for fft_bf_sched: a small N=8 instance checked every
// cycle against an expected schedule built from group/position loops, and a
// default N=8192 instance checked at its first and final butterflies.
module tb_fft_bf_sched;

  localparam int SN   = 8;
  localparam int SL   = 3;
  localparam int STW  = 2;
  localparam int SD   = 4;
  localparam int SCYC = SL * (SN / 2 + SD);
  localparam int NC   = SCYC + 2;

  localparam int BN   = 8192;
  localparam int BL   = 13;
  localparam int BTW  = 2;
  localparam int BD   = 8;
  localparam int BCYC = BL * (BN / 2 + BD);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic       rst_n8, start8;
  logic [1:0] k8;
  logic       twv8, bv8, last8, busy8, done8;
  logic [2:0] a8, b8, st8;
  // big instance
  logic        rst_nb, startb;
  logic [11:0] kb;
  logic        twvb, bvb, lastb, busyb, doneb;
  logic [12:0] ab, bb;
  logic [4:0]  stb;
`ifdef FFT_PERF_EN
  logic [31:0] cnt8, cntb;
`endif

  fft_bf_sched #(.N(SN), .TW_LAT(STW), .DRAIN_CYC(SD)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8),
    .tw_k(k8), .tw_k_valid(twv8), .bf_valid(bv8),
    .addr_a(a8), .addr_b(b8), .bf_stage(st8), .bf_last(last8),
    .busy(busy8), .done(done8)
`ifdef FFT_PERF_EN
    , .cycle_cnt(cnt8)
`endif
  );

  fft_bf_sched #(.N(BN), .TW_LAT(BTW), .DRAIN_CYC(BD)) dutb (
    .clk(clk), .rst_n(rst_nb), .start(startb),
    .tw_k(kb), .tw_k_valid(twvb), .bf_valid(bvb),
    .addr_a(ab), .addr_b(bb), .bf_stage(stb), .bf_last(lastb),
    .busy(busyb), .done(doneb)
`ifdef FFT_PERF_EN
    , .cycle_cnt(cntb)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // expected per-cycle schedule of one small run, index = cycle after start
  int e_twv [0:NC], e_k [0:NC], e_bv [0:NC], e_a [0:NC], e_b [0:NC];
  int e_st [0:NC], e_last [0:NC], e_busy [0:NC], e_done [0:NC];
  // values the held outputs carry into the next run
  int h_k, h_a, h_b, h_st, h_last;

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s c%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic build_small();
    for (int c = 0; c <= NC; c++) begin
      e_twv[c] = 0; e_bv[c] = 0; e_last[c] = 0;
      e_k[c] = 0; e_a[c] = 0; e_b[c] = 0; e_st[c] = 0;
      e_busy[c] = (c >= 1 && c <= SCYC) ? 1 : 0;
      e_done[c] = (c == SCYC + 1) ? 1 : 0;
    end
    e_k[0] = h_k; e_a[0] = h_a; e_b[0] = h_b; e_st[0] = h_st; e_last[0] = h_last;
    for (int s = 0; s < SL; s++) begin
      int half = 1 << s;
      for (int g = 0; g < SN / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          int j  = g * half + p;
          int c  = 1 + s * (SN / 2 + SD) + j;
          int cb = c + STW;
          e_twv[c]   = 1;
          e_k[c]     = p * (SN / (2 * half));
          e_bv[cb]   = 1;
          e_a[cb]    = g * 2 * half + p;
          e_b[cb]    = g * 2 * half + p + half;
          e_st[cb]   = s;
          e_last[cb] = (s == SL - 1 && j == SN / 2 - 1) ? 1 : 0;
        end
      end
    end
    for (int c = 1; c <= NC; c++) begin
      if (e_twv[c] == 0) e_k[c] = e_k[c-1];
      if (e_bv[c] == 0) begin
        e_a[c] = e_a[c-1]; e_b[c] = e_b[c-1];
        e_st[c] = e_st[c-1]; e_last[c] = e_last[c-1];
      end
    end
  endtask

  task automatic chk_small_zero(input int c);
    chk("rst_tw_k_valid", c, 32'(twv8), 0);
    chk("rst_tw_k", c, 32'(k8), 0);
    chk("rst_bf_valid", c, 32'(bv8), 0);
    chk("rst_addr_a", c, 32'(a8), 0);
    chk("rst_addr_b", c, 32'(b8), 0);
    chk("rst_bf_stage", c, 32'(st8), 0);
    chk("rst_bf_last", c, 32'(last8), 0);
    chk("rst_busy", c, 32'(busy8), 0);
    chk("rst_done", c, 32'(done8), 0);
`ifdef FFT_PERF_EN
    chk("rst_cycle_cnt", c, cnt8, 0);
`endif
  endtask

  // Caller drives start8=1 during c0; checks c1..c26 or aborts at abort_at.
  task automatic run_small(input int abort_at, input bit noise, input bit chain);
    build_small();
    for (int c = 1; c <= NC; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        #2 rst_n8 = 1'b0;
        #1 chk_small_zero(c);
        start8 = 1'b0;
        @(posedge clk); #1;
        chk_small_zero(c + 1);
        rst_n8 = 1'b1;
        h_k = 0; h_a = 0; h_b = 0; h_st = 0; h_last = 0;
        return;
      end
      chk("tw_k_valid", c, 32'(twv8), e_twv[c]);
      chk("tw_k", c, 32'(k8), e_k[c]);
      chk("bf_valid", c, 32'(bv8), e_bv[c]);
      chk("addr_a", c, 32'(a8), e_a[c]);
      chk("addr_b", c, 32'(b8), e_b[c]);
      chk("bf_stage", c, 32'(st8), e_st[c]);
      chk("bf_last", c, 32'(last8), e_last[c]);
      chk("busy", c, 32'(busy8), e_busy[c]);
      chk("done", c, 32'(done8), e_done[c]);
`ifdef FFT_PERF_EN
      if (c >= SCYC + 1) chk("cycle_cnt", c, cnt8, SCYC);
`endif
      if (c < NC) start8 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      else        start8 = chain;
    end
    h_k = e_k[NC]; h_a = e_a[NC]; h_b = e_b[NC]; h_st = e_st[NC]; h_last = e_last[NC];
  endtask

  initial begin
    int cb, last_c, done_c, la, lb, lk, lst, busy_at_done;
`ifdef FFT_PERF_EN
    int cnt_at_done;
    cnt_at_done = -1;
`endif
    h_k = 0; h_a = 0; h_b = 0; h_st = 0; h_last = 0;
    rst_n8 = 1'b0; rst_nb = 1'b0; start8 = 1'b0; startb = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_small_zero(0);
    chk("rst_big_busy", 0, 32'(busyb), 0);
    chk("rst_big_tw_k_valid", 0, 32'(twvb), 0);
    #2 rst_n8 = 1'b1; rst_nb = 1'b1;

    // plain run after a random idle gap
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 start8 = 1'b1;
    run_small(0, 1'b0, 1'b0);

    // noisy start while busy, start held into the next FFT
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 start8 = 1'b1;
    run_small(0, 1'b1, 1'b1);
    run_small(0, 1'b0, 1'b0);

    // abort mid-FFT, then a clean restart from stage 0
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 start8 = 1'b1;
    run_small(int'($urandom_range(2, 20)), 1'b1, 1'b0);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 start8 = 1'b1;
    run_small(0, 1'b0, 1'b0);

    // full-size default instance
    @(posedge clk); #1 startb = 1'b1;
    @(posedge clk); #1 startb = 1'b0;
    cb = 1; last_c = -1; done_c = -1;
    la = -1; lb = -1; lk = -1; lst = -1; busy_at_done = -1;
    while (done_c < 0 && cb < 60000) begin
      if (cb == 1) begin
        chk("big_first_tw_k_valid", cb, 32'(twvb), 1);
        chk("big_first_tw_k", cb, 32'(kb), 0);
      end
      if (cb == 1 + BTW) begin
        chk("big_first_bf_valid", cb, 32'(bvb), 1);
        chk("big_first_addr_b", cb, 32'(bb), 1);
      end
      if (bvb && lastb && last_c < 0) begin
        last_c = cb; la = int'(ab); lb = int'(bb); lk = int'(kb); lst = int'(stb);
      end
      if (doneb) begin
        done_c = cb;
        busy_at_done = int'(busyb);
`ifdef FFT_PERF_EN
        cnt_at_done = int'(cntb);
`endif
      end else begin
        @(posedge clk); #1;
        cb++;
      end
    end
    chk("big_last_cycle", last_c, last_c,
        1 + (BL - 1) * (BN / 2 + BD) + (BN / 2 - 1) + BTW);
    chk("big_last_addr_a", last_c, la, BN / 2 - 1);
    chk("big_last_addr_b", last_c, lb, BN - 1);
    chk("big_last_tw_k", last_c, lk, (BN / 2 - 1) * (BN / BN));
    chk("big_last_stage", last_c, lst, BL - 1);
    chk("big_done_cycle", done_c, done_c, BCYC + 1);
    chk("big_busy_at_done", done_c, busy_at_done, 0);
`ifdef FFT_PERF_EN
    chk("big_cycle_cnt", done_c, cnt_at_done, BCYC);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
